// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM target for the native memory bus with address decode, wait states and byte strobes
module mem_responder #(
    parameter int          ADDR_BITS   = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0] WAIT_LOAD = (WAIT_STATES > 0) ? 8'(WAIT_STATES - 1) : 8'd0;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             wstrb_q, wstrb_d;
    logic                   hit_q, hit_d;
    logic                   ready_q, ready_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   commit;
    logic [31:0]            ram [2**ADDR_BITS];
    logic                   unused_addr_lsbs;

    assign unused_addr_lsbs = ^mem_addr[1:0];
    assign mem_ready        = ready_q;
    assign mem_rdata        = rdata_q;

    // Latch the request in IDLE, count down wait states, and form the response on the edge entering RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        hit_d   = hit_q;
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    idx_d   = mem_addr[ADDR_BITS+1:2];
                    wdata_d = mem_wdata;
                    wstrb_d = mem_instr ? 4'b0000 : mem_wstrb;
                    hit_d   = mem_addr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2];
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd0) state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
        commit  = rst && state_d == S_RESP && state_q != S_RESP;
        ready_d = commit;
        rdata_d = (commit && hit_d && wstrb_d == 4'b0000) ? ram[idx_d] : 32'h0;
    end

    // Control and response registers; reset drops any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'b0000;
            hit_q   <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            hit_q   <= hit_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobed RAM write, committed on the same edge the response is registered; contents survive reset
    always_ff @(posedge clk) begin
        if (commit && hit_d) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_d[b]) ram[idx_d][8*b +: 8] <= wdata_d[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder against a word-array reference model
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid [3];
    logic        instr [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  wstrb [3];
    logic [31:0] rdata [3];
    logic        ready [3];

    int          vectors = 0;
    int          miscompares = 0;
    int          ws_of   [3] = '{0, 3, 4};
    logic [31:0] base_of [3] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
    logic [31:0] model   [3][4096];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_BITS(12), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .mem_valid(valid[0]), .mem_instr(instr[0]), .mem_addr(addr[0]),
        .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .mem_rdata(rdata[0]), .mem_ready(ready[0]));
    mem_responder #(.ADDR_BITS(12), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .rst(rst), .mem_valid(valid[1]), .mem_instr(instr[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .mem_rdata(rdata[1]), .mem_ready(ready[1]));
    mem_responder #(.ADDR_BITS(12), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(4)) u_dut2 (
        .clk(clk), .rst(rst), .mem_valid(valid[2]), .mem_instr(instr[2]), .mem_addr(addr[2]),
        .mem_wdata(wdata[2]), .mem_wstrb(wstrb[2]), .mem_rdata(rdata[2]), .mem_ready(ready[2]));

    // Reference: returns the expected response word and applies any write to the model
    function automatic logic [31:0] model_txn(input int k, input bit i, input logic [31:0] a,
                                              input logic [31:0] wd, input logic [3:0] st);
        logic [3:0]  eff = i ? 4'b0000 : st;
        bit          hit = (a >> 14) == (base_of[k] >> 14);
        int          idx = int'((a >> 2) % 4096);
        logic [31:0] exp = (hit && eff == 4'b0000) ? model[k][idx] : 32'h0;
        if (hit) for (int b = 0; b < 4; b++) if (eff[b]) model[k][idx][8*b +: 8] = wd[8*b +: 8];
        return exp;
    endfunction

    // Issue one request, scramble the bus after accept, report edges-to-ready, data and any trailing activity
    task automatic run_txn(input int k, input bit i, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] st, input bit drop,
                           output int lat, output logic [31:0] rd, output logic after);
        valid[k] = 1'b1; instr[k] = i; addr[k] = a; wdata[k] = wd; wstrb[k] = st;
        lat = -1; rd = 32'h0;
        for (int e = 0; e < ws_of[k] + 6 && lat < 0; e++) begin
            @(posedge clk); #1;
            if (e == 0) begin
                addr[k] = $urandom; wdata[k] = $urandom; wstrb[k] = 4'($urandom); instr[k] = 1'($urandom);
                if (drop) valid[k] = 1'b0;
            end
            if (ready[k] === 1'b1) begin lat = e; rd = rdata[k]; valid[k] = 1'b0; end
        end
        valid[k] = 1'b0; instr[k] = 1'b0;
        @(posedge clk); #1;
        after = ready[k] | (rdata[k] != 32'h0);
        @(posedge clk); #1;
        after = after | ready[k];
    endtask

    task automatic test_reset();
        int lat; logic [31:0] rd, exp, d; logic after;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin valid[k] = 0; instr[k] = 0; addr[k] = 0; wdata[k] = 0; wstrb[k] = 0; end
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (ready[k] !== 1'b0 || rdata[k] !== 32'h0) begin
                miscompares++; $display("FAIL reset_async dut%0d ready=%b rdata=%h want 0/0", k, ready[k], rdata[k]);
            end
        end
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 16; w++) begin
                d = $urandom;
                exp = model_txn(k, 0, base_of[k] + 32'(4 * w), d, 4'hF);
                run_txn(k, 0, base_of[k] + 32'(4 * w), d, 4'hF, 0, lat, rd, after);
                vectors++;
                if (lat !== ws_of[k] || rd !== exp || after !== 1'b0) begin
                    miscompares++;
                    $display("FAIL preload dut%0d w%0d lat=%0d rd=%h after=%b want %0d/%h/0", k, w, lat, rd, after, ws_of[k], exp);
                end
            end
        end
    endtask

    task automatic test_read();
        int lat; logic [31:0] rd; logic after;
        void'(model_txn(0, 0, 32'h14, 32'hDEAD_BEEF, 4'hF));
        run_txn(0, 0, 32'h14, 32'hDEAD_BEEF, 4'hF, 0, lat, rd, after);
        run_txn(0, 0, 32'h14, 32'h0, 4'h0, 0, lat, rd, after);
        vectors++;
        if (lat !== 0 || rd !== 32'hDEAD_BEEF || after !== 1'b0) begin
            miscompares++; $display("FAIL read_basic lat=%0d rd=%h after=%b want 0/deadbeef/0", lat, rd, after);
        end
    endtask

    task automatic test_strobes();
        int lat; logic [31:0] rd; logic after;
        void'(model_txn(0, 0, 32'h8, 32'h1122_3344, 4'hF));
        run_txn(0, 0, 32'h8, 32'h1122_3344, 4'hF, 0, lat, rd, after);
        void'(model_txn(0, 0, 32'h8, 32'hAABB_CCDD, 4'b0101));
        run_txn(0, 0, 32'h8, 32'hAABB_CCDD, 4'b0101, 0, lat, rd, after);
        vectors++;
        if (rd !== 32'h0 || after !== 1'b0) begin
            miscompares++; $display("FAIL strobe_write rd=%h after=%b want 0/0", rd, after);
        end
        run_txn(0, 0, 32'h8, 32'h0, 4'h0, 0, lat, rd, after);
        vectors++;
        if (rd !== 32'h11BB_33DD) begin
            miscompares++; $display("FAIL strobe_read got %h want 11bb33dd", rd);
        end
    endtask

    task automatic test_wait_states();
        int lat; logic [31:0] rd, exp; logic after;
        exp = model_txn(1, 0, 32'h8000_0014, 32'h0, 4'h0);
        run_txn(1, 0, 32'h8000_0014, 32'h0, 4'h0, 1, lat, rd, after);
        vectors++;
        if (lat !== 3 || rd !== exp || after !== 1'b0) begin
            miscompares++; $display("FAIL wait_drop lat=%0d rd=%h after=%b want 3/%h/0", lat, rd, after, exp);
        end
    endtask

    task automatic test_fetch_miss();
        int lat; logic [31:0] rd, exp; logic after;
        exp = model_txn(0, 1, 32'h8, 32'h5555_AAAA, 4'hF);
        run_txn(0, 1, 32'h8, 32'h5555_AAAA, 4'hF, 0, lat, rd, after);
        vectors++;
        if (rd !== exp || exp !== 32'h11BB_33DD) begin
            miscompares++; $display("FAIL fetch_strobe got %h want 11bb33dd", rd);
        end
        run_txn(0, 0, 32'h8, 32'h0, 4'h0, 0, lat, rd, after);
        vectors++;
        if (rd !== 32'h11BB_33DD) begin
            miscompares++; $display("FAIL fetch_no_write got %h want 11bb33dd", rd);
        end
        run_txn(1, 0, 32'h0000_0010, 32'h0, 4'h0, 0, lat, rd, after);
        vectors++;
        if (lat !== 3 || rd !== 32'h0) begin
            miscompares++; $display("FAIL miss_read lat=%0d rd=%h want 3/0", lat, rd);
        end
        void'(model_txn(1, 0, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF));
        run_txn(1, 0, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF, 0, lat, rd, after);
        exp = model_txn(1, 0, 32'h8000_0010, 32'h0, 4'h0);
        run_txn(1, 0, 32'h8000_0010, 32'h0, 4'h0, 0, lat, rd, after);
        vectors++;
        if (rd !== exp) begin
            miscompares++; $display("FAIL miss_write got %h want %h", rd, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e0, e1;
        logic        seen;
        e0 = model_txn(0, 0, 32'h0, 32'h0, 4'h0);
        e1 = model_txn(0, 0, 32'h4, 32'h0, 4'h0);
        valid[0] = 1'b1; instr[0] = 1'b0; addr[0] = 32'h0; wstrb[0] = 4'h0;
        @(posedge clk); #1;
        vectors++;
        if (ready[0] !== 1'b1 || rdata[0] !== e0) begin
            miscompares++; $display("FAIL b2b_first ready=%b rd=%h want 1/%h", ready[0], rdata[0], e0);
        end
        addr[0] = 32'h4;
        @(posedge clk); #1;
        vectors++;
        if (ready[0] !== 1'b0) begin
            miscompares++; $display("FAIL b2b_gap ready=%b want 0", ready[0]);
        end
        @(posedge clk); #1;
        vectors++;
        if (ready[0] !== 1'b1 || rdata[0] !== e1) begin
            miscompares++; $display("FAIL b2b_second ready=%b rd=%h want 1/%h", ready[0], rdata[0], e1);
        end
        valid[0] = 1'b0;
        seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; seen = seen | ready[0]; end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++; $display("FAIL b2b_duplicate ready=%b want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd, old; logic after, seen;
        old = model[2][3];
        valid[2] = 1'b1; instr[2] = 1'b0; addr[2] = 32'hC; wdata[2] = ~old; wstrb[2] = 4'hF;
        @(posedge clk); #1;
        valid[2] = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (ready[2] !== 1'b0 || rdata[2] !== 32'h0) begin
            miscompares++; $display("FAIL rst_wait_outputs ready=%b rd=%h want 0/0", ready[2], rdata[2]);
        end
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; seen = seen | ready[2]; end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++; $display("FAIL rst_wait_ready ready=%b want 0", seen);
        end
        run_txn(2, 0, 32'hC, 32'h0, 4'h0, 0, lat, rd, after);
        vectors++;
        if (lat !== 4 || rd !== old) begin
            miscompares++; $display("FAIL rst_wait_ram lat=%0d rd=%h want 4/%h", lat, rd, old);
        end
    endtask

    task automatic test_reset_resp();
        int lat; logic [31:0] rd, d; logic after;
        d = $urandom;
        void'(model_txn(0, 0, 32'h18, d, 4'hF));
        valid[0] = 1'b1; instr[0] = 1'b0; addr[0] = 32'h18; wdata[0] = d; wstrb[0] = 4'hF;
        @(posedge clk); #1;
        vectors++;
        if (ready[0] !== 1'b1) begin
            miscompares++; $display("FAIL rst_resp_pre ready=%b want 1", ready[0]);
        end
        valid[0] = 1'b0;
        rst = 1'b0;
        #1;
        vectors++;
        if (ready[0] !== 1'b0 || rdata[0] !== 32'h0) begin
            miscompares++; $display("FAIL rst_resp_async ready=%b rd=%h want 0/0", ready[0], rdata[0]);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        run_txn(0, 0, 32'h18, 32'h0, 4'h0, 0, lat, rd, after);
        vectors++;
        if (rd !== d) begin
            miscompares++; $display("FAIL rst_resp_ram got %h want %h", rd, d);
        end
    endtask

    task automatic test_random();
        int lat, k, w; bit i; logic [31:0] a, d, exp, rd; logic [3:0] st; logic after;
        for (int n = 0; n < 90; n++) begin
            k  = $urandom_range(0, 2);
            i  = $urandom_range(0, 3) == 0;
            w  = $urandom_range(0, 15);
            a  = (($urandom_range(0, 4) != 0) ? base_of[k] : base_of[k] ^ 32'h4000_0000)
                 + 32'(4 * w) + 32'($urandom_range(0, 3));
            d  = $urandom;
            st = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            exp = model_txn(k, i, a, d, st);
            run_txn(k, i, a, d, st, $urandom_range(0, 1) == 1, lat, rd, after);
            vectors++;
            if (lat !== ws_of[k] || rd !== exp || after !== 1'b0) begin
                miscompares++;
                $display("FAIL random n%0d dut%0d a=%h st=%h i=%0d lat=%0d rd=%h after=%b want %0d/%h/0",
                         n, k, a, st, i, lat, rd, after, ws_of[k], exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_strobes();
        test_wait_states();
        test_fetch_miss();
        test_back_to_back();
        test_reset_mid();
        test_reset_resp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Target (responder) end of the core's native memory bus: valid/instr/addr/wdata/wstrb in, rdata/ready out.
- Answers the requests the core-side arbiter issues, backed by a word-organised on-chip RAM.
- Decodes its own address window, inserts a programmable number of wait states and applies byte strobes on writes.
- Used as boot/data RAM in simulation tops and small FPGA builds.

Parameters:
ADDR_BITS, 12, number of word-index bits; RAM depth = 2**ADDR_BITS 32-bit words.
BASE_ADDR, 32'h0000_0000, window base; must be aligned to 4*2**ADDR_BITS bytes.
WAIT_STATES, 0, extra cycles between accept and ready; legal range 0..255.

Ports:
rst  input  1  asynchronous reset, active-low
clk  input  1  clock, all state on rising edge
mem_valid  input  1  request present; held high by initiator until it samples mem_ready=1
mem_instr  input  1  request is an instruction fetch
mem_addr  input  32  byte address; bits [1:0] ignored
mem_wdata  input  32  write data
mem_wstrb  input  4  byte write enables; 0 = read
mem_rdata  output  32  read data, valid only while mem_ready=1
mem_ready  output  1  one-cycle completion pulse

Behaviour:
- Reset: rst=0 forces state IDLE, mem_ready=0, mem_rdata=0 and wait counter=0 immediately, with no clock required. RAM contents are not reset.
- Decode:
  - hit = (mem_addr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]).
  - Word index = mem_addr[ADDR_BITS+1:2].
- FSM state IDLE:
  - mem_ready=0.
  - If mem_valid=1, latch instr, index, wdata, effective wstrb and hit.
  - Effective wstrb is forced to 0 when mem_instr=1: fetches are always reads.
  - Go to WAIT if WAIT_STATES>0, loading the counter with WAIT_STATES-1; otherwise go to RESP.
- FSM state WAIT:
  - Counter decrements every cycle; go to RESP on the edge where the counter is 0.
  - mem_valid is not re-sampled; the latched request completes even if the initiator drops valid.
- RAM update and response data are applied on the edge entering RESP:
  - Write with hit: update each byte i where wstrb[i]=1 (bits [8i+7:8i]); other bytes unchanged. mem_rdata=0.
  - Read with hit: mem_rdata = RAM[index], the value before any same-edge write.
  - Miss: write discarded, mem_rdata=0. The bus has no error signal; a miss completes normally.
- FSM state RESP:
  - mem_ready=1 for exactly one cycle; mem_rdata holds the response.
  - Next edge: go to IDLE, mem_ready=0, mem_rdata=0.
- Back-to-back: the cycle after RESP is IDLE. If mem_valid is high there, it is a new request and is accepted that cycle.
- Latency: request accepted at edge N gives mem_ready=1 in cycle N+1+WAIT_STATES. Throughput is one transaction per 2+WAIT_STATES cycles.
- mem_ready is never asserted outside RESP. It is never asserted twice for one accepted request.
- Reset during WAIT: request dropped, no RAM write, no ready. Reset during RESP: ready drops asynchronously; the RAM write already committed stays.
- Changes on mem_addr/mem_wdata/mem_wstrb after accept have no effect on the transaction in flight.
- All addresses and strobe combinations are legal, including non-contiguous wstrb patterns (e.g. 4'b1010).

Test Plan:
1. Reset/read: WAIT_STATES=0, rst low then high. Preload RAM[5]=32'hDEAD_BEEF. Read addr 32'h14 -> mem_ready=1 exactly one cycle after accept with mem_rdata=32'hDEAD_BEEF; mem_rdata=0 the next cycle.
2. Byte strobes: RAM[2]=32'h1122_3344. Write addr 32'h8, wdata 32'hAABB_CCDD, wstrb 4'b0101. Then read addr 32'h8 -> 32'h11BB_33DD.
3. Wait states: WAIT_STATES=3. Read accepted at edge N -> mem_ready high only in cycle N+4. Drop mem_valid in cycle N+1 -> response still delivered once.
4. Fetch with strobe and miss:
   - mem_instr=1, wstrb 4'hF, addr 32'h8 -> RAM[2] unchanged; returns stored word.
   - BASE_ADDR=32'h8000_0000, read addr 32'h0000_0010 -> ready with rdata 0.
   - Miss write -> no RAM change.
5. Back-to-back: hold mem_valid high across consecutive requests (addr 32'h0, then 32'h4, wstrb 0). Ready pulses every 2 cycles with WAIT_STATES=0 and each returns the correct word; no request is lost or duplicated.
6. Reset mid-op: WAIT_STATES=4. Write accepted, assert rst=0 two cycles later -> no ready, outputs 0 asynchronously. Read-back after reset release shows the old RAM value.
